// File: rtl/dmem_responder.sv
// Data-memory responder: word storage with a one-cycle registered read,
// a post-reset clear sweep and bad-address flagging.
module dmem_responder #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_mem_write,
   input  logic [DATA_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_write_data,
   output logic [DATA_WIDTH-1:0] o_read_data,
   output logic                  o_busy,
   output logic                  o_addr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [AW-1:0]         clr_idx;
   logic [AW-1:0]         clr_nxt;
   logic [DATA_WIDTH-1:0] rdata_nxt;
   logic                  busy_nxt;
   logic                  err_nxt;
   logic                  wr_en;
   logic [AW-1:0]         wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [DATA_WIDTH-1:0] offset;
   logic                  in_range;
   logic                  aligned;
   logic                  ok;
   logic [AW-1:0]         idx;

   // BASE_ADDR is word aligned, so the low offset bits mirror the address.
   assign offset   = i_addr - BASE_ADDR;
   assign in_range = (offset[DATA_WIDTH-1:AW+2] == '0);
   assign aligned  = (offset[1:0] == 2'b00);
   assign ok       = in_range & aligned;
   assign idx      = offset[AW+1:2];

   // Next-state, storage write port and next output values.
   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_idx;
      rdata_nxt = o_read_data;
      busy_nxt  = o_busy;
      err_nxt   = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = idx;
      wr_data   = i_write_data;
      unique case (state)
         CLEAR: begin
            wr_en     = 1'b1;
            wr_idx    = clr_idx;
            wr_data   = '0;
            clr_nxt   = clr_idx + AW'(1);
            rdata_nxt = '0;
            busy_nxt  = 1'b1;
            if (clr_idx == LAST) begin
               state_nxt = READY;
               busy_nxt  = 1'b0;
            end
         end
         READY: begin
            busy_nxt = 1'b0;
            if (ok) begin
               wr_en     = i_mem_write;
               rdata_nxt = i_mem_write ? i_write_data : mem[idx];
            end else begin
               rdata_nxt = '0;
               err_nxt   = 1'b1;
            end
         end
      endcase
   end

   // State, sweep index and registered outputs; reset restarts the sweep.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= CLEAR;
         clr_idx     <= '0;
         o_read_data <= '0;
         o_busy      <= 1'b1;
         o_addr_err  <= 1'b0;
      end else begin
         state       <= state_nxt;
         clr_idx     <= clr_nxt;
         o_read_data <= rdata_nxt;
         o_busy      <= busy_nxt;
         o_addr_err  <= err_nxt;
      end
   end

   // Storage write port; a reset edge never writes.
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: behavioural model compared every cycle,
// plus directed checks with literal expected values.
module tb_dmem_responder;

   localparam int DW    = 32;
   localparam int DEPTH = 256;
   localparam logic [31:0] BASE = 32'h0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mem_write = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   write_data = '0;
   logic [31:0]   read_data;
   logic          busy;
   logic          addr_err;

   int total = 0;
   int bad   = 0;

   dmem_responder #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_mem_write  (mem_write),
      .i_addr       (addr),
      .i_write_data (write_data),
      .o_read_data  (read_data),
      .o_busy       (busy),
      .o_addr_err   (addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: word array, remaining-sweep counter, expected outputs.
   logic [31:0] model_mem [DEPTH];
   int          sweep_left = 0;
   bit          model_on = 0;
   logic [31:0] exp_rd = '0;
   logic        exp_busy = 1'b1;
   logic        exp_err = 1'b0;

   always @(posedge clk) begin
      logic [31:0] off;
      if (!rst) begin
         model_on   = 1;
         sweep_left = DEPTH;
         exp_busy   = 1'b1;
         exp_rd     = '0;
         exp_err    = 1'b0;
         for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end else if (sweep_left > 0) begin
         sweep_left = sweep_left - 1;
         exp_busy   = (sweep_left != 0);
         exp_rd     = '0;
         exp_err    = 1'b0;
      end else begin
         off = addr - BASE;
         exp_busy = 1'b0;
         if (off < 32'(4 * DEPTH) && addr % 4 == 0) begin
            if (mem_write) model_mem[off / 4] = write_data;
            exp_rd  = model_mem[off / 4];
            exp_err = 1'b0;
         end else begin
            exp_rd  = '0;
            exp_err = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (model_on) begin
         chk("cyc_busy", {31'b0, busy}, {31'b0, exp_busy});
         chk("cyc_rdata", read_data, exp_rd);
         chk("cyc_err", {31'b0, addr_err}, {31'b0, exp_err});
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic access(input logic we, input logic [31:0] a,
                         input logic [31:0] d);
      mem_write  = we;
      addr       = a;
      write_data = d;
      tick();
   endtask

   task automatic count_sweep(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         n++;
         if (!busy) break;
      end
      chk(name, 32'(n), 32'd256);
   endtask

   initial begin
      rst = 1'b0;
      tick();
      tick();
      chk("rst_busy", {31'b0, busy}, 32'd1);
      chk("rst_rdata", read_data, 32'h0);
      chk("rst_err", {31'b0, addr_err}, 32'd0);
      rst = 1'b1;
      // Inputs during the sweep must be ignored.
      mem_write  = 1'b1;
      addr       = 32'h10;
      write_data = 32'h5555_0000;
      count_sweep("sweep_len");

      access(1'b0, 32'h0, 32'h0);
      chk("rd0_zero", read_data, 32'h0);
      access(1'b0, 32'h3FC, 32'h0);
      chk("rd3fc_zero", read_data, 32'h0);
      chk("rd3fc_err", {31'b0, addr_err}, 32'd0);

      access(1'b1, 32'h10, 32'hDEAD_BEEF);
      access(1'b0, 32'h10, 32'h0);
      chk("rd10", read_data, 32'hDEAD_BEEF);
      chk("rd10_err", {31'b0, addr_err}, 32'd0);

      access(1'b1, 32'h20, 32'h1234_5678);
      chk("wfirst20", read_data, 32'h1234_5678);

      access(1'b1, 32'h400, 32'hFFFF_FFFF);
      chk("oor_err", {31'b0, addr_err}, 32'd1);
      chk("oor_rdata", read_data, 32'h0);
      access(1'b0, 32'h0, 32'h0);
      chk("oor_pulse", {31'b0, addr_err}, 32'd0);
      chk("oor_noalias", read_data, 32'h0);

      access(1'b1, 32'h11, 32'hAAAA_5555);
      chk("mis_err", {31'b0, addr_err}, 32'd1);
      access(1'b0, 32'h10, 32'h0);
      chk("mis_keep", read_data, 32'hDEAD_BEEF);

      access(1'b1, 32'h3FC, 32'h0BAD_F00D);
      access(1'b0, 32'h3FC, 32'h0);
      chk("top_word", read_data, 32'h0BAD_F00D);
      access(1'b1, 32'hFFFF_FFFC, 32'h1);
      chk("wrap_err", {31'b0, addr_err}, 32'd1);
      access(1'b0, 32'h3FC, 32'h0);
      chk("wrap_keep", read_data, 32'h0BAD_F00D);
      access(1'b0, 32'h20, 32'h0);
      chk("rd20", read_data, 32'h1234_5678);

      // Reset in READY: storage is swept back to zero.
      mem_write = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      // Reset mid-sweep restarts it from the beginning.
      rst = 1'b0;
      tick();
      chk("mid_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      count_sweep("resweep_len");
      access(1'b0, 32'h10, 32'h0);
      chk("post_rst_rd10", read_data, 32'h0);
      access(1'b0, 32'h3FC, 32'h0);
      chk("post_rst_top", read_data, 32'h0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
